// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: redirect input, instruction-memory handshake and decode-side queue head.
// master = fetch queue, slave = surrounding pipeline / memory.
interface inst_fetch_queue_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              req_valid;
    logic [31:0]       req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              out_valid;
    logic [31:0]       out_pc;
    logic [DATA_W-1:0] out_instr;
    logic              out_adel;
    logic              out_ready;
    logic [CNT_W-1:0]  count;

    modport master (
        input  redirect, redirect_pc, req_ready, resp_valid, resp_data, out_ready,
        output req_valid, req_addr, out_valid, out_pc, out_instr, out_adel, count
    );

    modport slave (
        output redirect, redirect_pc, req_ready, resp_valid, resp_data, out_ready,
        input  req_valid, req_addr, out_valid, out_pc, out_instr, out_adel, count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one request in flight,
// buffers returned words (with PC and address-error flag) in a DEPTH-entry FIFO.
// Optional feature macro: FETCHQ_BYPASS_EN (empty-queue response forwarded to out_* in the
// same cycle; consumed without a write when out_ready is high).
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DATA_W   = 32,
    parameter logic [31:0] PC_RESET = 32'hBFC00000
) (
    input  logic             clk,
    input  logic             rst,
    inst_fetch_queue_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]       pc_q, pc_d;
    logic [31:0]       issue_pc_q, issue_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              inflight_q, inflight_d;
    logic              drop_q, drop_d;
    logic              halted_q, halted_d;

    logic [31:0]       mem_pc_q    [DEPTH];
    logic [DATA_W-1:0] mem_instr_q [DEPTH];
    logic              mem_adel_q  [DEPTH];

    logic              resp_take_c, resp_push_c, bypass_c, fifo_valid_c;
    logic              push_c, pop_c, space_c, fetch_ok_c, req_valid_c, hs_c;
    logic              misalign_c, wr_en_c;
    logic [SUM_W-1:0]  sum_c;
    logic [31:0]       wr_pc_c;
    logic [DATA_W-1:0] wr_instr_c;

    // Handshake decode, issue rule and queue-head presentation
    always_comb begin
        resp_take_c  = bus.resp_valid && inflight_q;
        resp_push_c  = resp_take_c && !drop_q;
        fifo_valid_c = (count_q != '0);
`ifdef FETCHQ_BYPASS_EN
        bypass_c     = !fifo_valid_c && resp_push_c;
`else
        bypass_c     = 1'b0;
`endif
        pop_c        = fifo_valid_c && bus.out_ready;
        push_c       = resp_push_c && !(bypass_c && bus.out_ready);
        // Occupancy if everything outstanding lands: queued + in flight - leaving + arriving
        sum_c        = SUM_W'(count_q) + SUM_W'(inflight_q) + SUM_W'(push_c) - SUM_W'(pop_c);
        space_c      = sum_c < SUM_W'(DEPTH);
        fetch_ok_c   = !rst && !bus.redirect && !halted_q && space_c;
        req_valid_c  = fetch_ok_c && (pc_q[1:0] == 2'b00) && (!inflight_q || bus.resp_valid);
        hs_c         = req_valid_c && bus.req_ready;
        // A misaligned PC only arises from a redirect, so it never collides with a response push
        misalign_c   = fetch_ok_c && (pc_q[1:0] != 2'b00) && !push_c;
        wr_en_c      = !bus.redirect && (push_c || misalign_c);
        wr_pc_c      = misalign_c ? pc_q : issue_pc_q;
        wr_instr_c   = misalign_c ? '0 : bus.resp_data;

        bus.req_valid = req_valid_c;
        bus.req_addr  = pc_q;
        bus.count     = count_q;
        bus.out_valid = fifo_valid_c || bypass_c;
        bus.out_pc    = '0;
        bus.out_instr = '0;
        bus.out_adel  = 1'b0;
        if (fifo_valid_c) begin
            bus.out_pc    = mem_pc_q[rd_ptr_q];
            bus.out_instr = mem_instr_q[rd_ptr_q];
            bus.out_adel  = mem_adel_q[rd_ptr_q];
        end else if (bypass_c) begin
            bus.out_pc    = issue_pc_q;
            bus.out_instr = bus.resp_data;
        end
    end

    // Next-state: redirect flushes everything, otherwise issue / response / push / pop
    always_comb begin
        pc_d       = pc_q;
        issue_pc_d = issue_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        halted_d   = halted_q;
        if (bus.redirect) begin
            pc_d       = bus.redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            halted_d   = 1'b0;
            inflight_d = inflight_q && !bus.resp_valid;
            drop_d     = inflight_q && !bus.resp_valid;
        end else begin
            if (resp_take_c) begin
                inflight_d = 1'b0;
                drop_d     = 1'b0;
            end
            if (hs_c) begin
                inflight_d = 1'b1;
                issue_pc_d = pc_q;
                pc_d       = pc_q + 32'd4;
            end
            if (misalign_c) begin
                halted_d = 1'b1;
            end
            if (wr_en_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(wr_en_c) - CNT_W'(pop_c);
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= PC_RESET;
            issue_pc_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            issue_pc_q <= issue_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            halted_q   <= halted_d;
        end
    end

    // FIFO storage; contents are masked at the output while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_pc_q[wr_ptr_q]    <= wr_pc_c;
            mem_instr_q[wr_ptr_q] <= wr_instr_c;
            mem_adel_q[wr_ptr_q]  <= misalign_c;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: one-outstanding memory model, scoreboard of expected queue
// entries, a per-cycle vector table for the fill/drain sequence, and directed corner cases.
module tb_inst_fetch_queue;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;
    inst_fetch_queue_if #(.DATA_W(32), .DEPTH(DEPTH)) bus ();

    inst_fetch_queue #(.DEPTH(DEPTH), .DATA_W(32), .PC_RESET(32'hBFC00000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } exp_t;

    typedef struct {
        logic        out_ready;
        logic        rv;
        logic [31:0] addr;
        logic [31:0] cnt;
        logic        ov;
    } vec_t;

    exp_t sb[$];
    vec_t vt[15];

    int checks;
    int failures;
    int mem_cnt;
    int mem_lat;
    logic [31:0] mem_addr;

    logic        nx_redirect;
    logic [31:0] nx_rpc;
    logic        nx_req_ready;
    logic        nx_out_ready;

    logic        s_rv;
    logic [31:0] s_addr;
    logic [31:0] s_cnt;
    logic        s_ov;
    logic [31:0] s_out_pc;
    logic        s_hs;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs at negedge, sample, score, advance the memory model
    task automatic step();
        exp_t e;
        @(negedge clk);
        bus.redirect    = nx_redirect;
        bus.redirect_pc = nx_rpc;
        bus.req_ready   = nx_req_ready;
        bus.out_ready   = nx_out_ready;
        bus.resp_valid  = (mem_cnt == 1);
        bus.resp_data   = (mem_cnt == 1) ? instr_of(mem_addr) : 32'h0;
        #1;
        s_rv     = bus.req_valid;
        s_addr   = bus.req_addr;
        s_cnt    = 32'(bus.count);
        s_ov     = bus.out_valid;
        s_out_pc = bus.out_pc;
        s_hs     = bus.req_valid && bus.req_ready;
        if (bus.out_valid && bus.out_ready && !bus.redirect) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual_pc=%h required=none", bus.out_pc);
            end else begin
                e = sb.pop_front();
                check("out_pc", bus.out_pc, e.pc);
                check("out_instr", bus.out_instr, e.instr);
                check("out_adel", 32'(bus.out_adel), 32'(e.adel));
            end
        end
        if (bus.redirect) begin
            sb.delete();
            if (bus.redirect_pc[1:0] != 2'b00) sb.push_back('{bus.redirect_pc, 32'h0, 1'b1});
        end
        if (mem_cnt > 0) mem_cnt--;
        if (s_hs) begin
            sb.push_back('{bus.req_addr, instr_of(bus.req_addr), 1'b0});
            mem_addr = bus.req_addr;
            mem_cnt  = mem_lat;
        end
    endtask

    initial begin
        logic [31:0] held;
        bit found;
        checks = 0;
        failures = 0;
        mem_cnt = 0;
        mem_lat = 1;
        mem_addr = '0;
        nx_redirect = 1'b0;
        nx_rpc = '0;
        nx_req_ready = 1'b1;
        nx_out_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.req_ready = 1'b1;
        bus.resp_valid = 1'b0;
        bus.resp_data = '0;
        bus.out_ready = 1'b0;

        //            out_ready rv    addr           cnt ov
        vt[0]  = '{1'b0, 1'b1, 32'hBFC00000, 0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 32'hBFC00004, 0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 32'hBFC00008, 1, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 32'h0,        2, 1'b1};
        vt[4]  = '{1'b0, 1'b1, 32'hBFC0000C, 3, 1'b1};
        vt[5]  = '{1'b0, 1'b0, 32'h0,        3, 1'b1};
        vt[6]  = '{1'b0, 1'b0, 32'h0,        4, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 32'h0,        4, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 32'h0,        4, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 32'h0,        4, 1'b1};
        vt[10] = '{1'b1, 1'b1, 32'hBFC00010, 4, 1'b1};
        vt[11] = '{1'b1, 1'b0, 32'h0,        3, 1'b1};
        vt[12] = '{1'b1, 1'b1, 32'hBFC00014, 3, 1'b1};
        vt[13] = '{1'b1, 1'b1, 32'hBFC00018, 2, 1'b1};
        vt[14] = '{1'b1, 1'b1, 32'hBFC0001C, 2, 1'b1};

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(bus.req_valid), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_out_instr", bus.out_instr, 0);
        check("rst_out_adel", 32'(bus.out_adel), 0);
        check("rst_req_addr", bus.req_addr, 32'hBFC00000);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill with decode stalled, then drain
        for (int i = 0; i < 15; i++) begin
            nx_out_ready = vt[i].out_ready;
            step();
            check($sformatf("vec%0d_req_valid", i), 32'(s_rv), 32'(vt[i].rv));
            if (vt[i].rv) check($sformatf("vec%0d_req_addr", i), s_addr, vt[i].addr);
            check($sformatf("vec%0d_count", i), s_cnt, vt[i].cnt);
            check($sformatf("vec%0d_out_valid", i), 32'(s_ov), 32'(vt[i].ov));
        end

        // Free-running: one instruction per cycle, occupancy bounded by 2
        for (int i = 0; i < 20; i++) begin
            step();
            check("free_out_valid", 32'(s_ov), 1);
            check("free_count_le2", 32'(s_cnt > 2), 0);
        end

        // Memory back-pressure: request held stable, nothing pushed
        nx_req_ready = 1'b0;
        step();
        held = s_addr;
        check("stall_req_valid0", 32'(s_rv), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_req_valid", 32'(s_rv), 1);
            check("stall_req_addr", s_addr, held);
        end
        check("stall_count", s_cnt, 0);
        check("stall_out_valid", 32'(s_ov), 0);
        check("stall_sb_empty", 32'(sb.size()), 0);
        nx_req_ready = 1'b1;

        // Redirect with a request in flight whose response lands after the redirect
        mem_lat = 2;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = s_hs;
        end
        check("redir_hs_seen", 32'(found), 1);
        nx_redirect = 1'b1;
        nx_rpc = 32'h80000180;
        step();
        check("redir_cycle_req_valid", 32'(s_rv), 0);
        nx_redirect = 1'b0;
        step();
        check("redir_next_req_valid", 32'(s_rv), 1);
        check("redir_next_req_addr", s_addr, 32'h80000180);
        check("redir_next_out_valid", 32'(s_ov), 0);
        check("redir_next_count", s_cnt, 0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = s_ov;
        end
        check("redir_out_seen", 32'(found), 1);
        check("redir_first_out_pc", s_out_pc, 32'h80000180);
        mem_lat = 1;

        // Misaligned redirect target: one address-error entry, fetch halts
        nx_redirect = 1'b1;
        nx_rpc = 32'h00400002;
        step();
        nx_redirect = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("adel_req_valid", 32'(s_rv), 0);
        end
        check("adel_sb_empty", 32'(sb.size()), 0);
        check("adel_count", s_cnt, 0);
        nx_redirect = 1'b1;
        nx_rpc = 32'h00400000;
        step();
        nx_redirect = 1'b0;
        step();
        check("resume_req_valid", 32'(s_rv), 1);
        check("resume_req_addr", s_addr, 32'h00400000);

        // Reset mid-stream with three entries queued
        nx_out_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = (s_cnt == 3);
        end
        check("mid_count3_seen", 32'(found), 1);
        @(negedge clk);
        bus.resp_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check("mid_rst_count", 32'(bus.count), 0);
        check("mid_rst_req_valid", 32'(bus.req_valid), 0);
        sb.delete();
        mem_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        nx_out_ready = 1'b1;
        step();
        check("post_rst_req_valid", 32'(s_rv), 1);
        check("post_rst_req_addr", s_addr, 32'hBFC00000);
        repeat (8) step();
        check("post_rst_out_pc_seq", 32'(sb.size() <= 2), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
